// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and note indices for the note synthesizer audio path
package audio_pkg;
    localparam int N_NOTES  = 12;
    localparam int SAMPLE_W = 8;
    localparam int VOL_W    = 4;
    localparam int CLK_HZ   = 25_000_000;
    localparam int IDX_DO   = 0;
    localparam int IDX_DOS  = 1;
    localparam int IDX_RE   = 2;
    localparam int IDX_RES  = 3;
    localparam int IDX_MI   = 4;
    localparam int IDX_FA   = 5;
    localparam int IDX_FAS  = 6;
    localparam int IDX_SOL  = 7;
    localparam int IDX_SOLS = 8;
    localparam int IDX_LA   = 9;
    localparam int IDX_LAS  = 10;
    localparam int IDX_SI   = 11;
endpackage

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order sigma-delta modulator, carry of the accumulator is the output bit
module sigma_delta_dac
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] din,
    output logic                dout
);
    logic [SAMPLE_W-1:0] acc_q;
    logic                dout_q;
    logic [SAMPLE_W:0]   sum;
    assign sum  = {1'b0, acc_q} + {1'b0, din};
    assign dout = dout_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            acc_q  <= sum[SAMPLE_W-1:0];
            dout_q <= sum[SAMPLE_W];
        end
    end
endmodule

// File: rtl/audio_mixer_dac.sv
// audio_mixer_dac: popcount mixer of note waves, volume scaling with saturation, sigma-delta output.
// Define AUDIO_ENVELOPE_EN to ramp the gain one step per sample tick towards vol.
module audio_mixer_dac
    import audio_pkg::*;
#(
    parameter int N_VOICES   = N_NOTES,
    parameter int SAMPLE_DIV = 256,
    parameter int MIX_SHIFT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_VOICES-1:0] onda,
    input  logic [VOL_W-1:0]    vol,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                clip,
    output logic                audio_out
);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int MW = $clog2(N_VOICES + 1);
    localparam int LW = MW + VOL_W + MIX_SHIFT + 1;
    logic [N_VOICES-1:0] meta_q, onda_s_q;
    logic [DW-1:0]       div_q;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sample_valid_q, clip_q, tick, sat;
    logic [MW-1:0]       mix;
    logic [VOL_W-1:0]    g;
    logic [LW-1:0]       lvl;
    assign tick = div_q == DW'(SAMPLE_DIV - 1);
`ifdef AUDIO_ENVELOPE_EN
    logic [VOL_W-1:0] g_q;
    assign g = g_q < vol ? g_q + 1'b1 : g_q > vol ? g_q - 1'b1 : g_q;
`else
    assign g = vol;
`endif
    always_comb begin
        mix = '0;
        for (int i = 0; i < N_VOICES; i++) mix = mix + MW'(onda_s_q[i]);
    end
    // Full-width product so saturation sees the true level before truncation.
    assign lvl      = (LW'(mix) * LW'(g)) << MIX_SHIFT;
    assign sat      = lvl > LW'((1 << SAMPLE_W) - 1);
    assign sample_d = sat ? '1 : lvl[SAMPLE_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q         <= '0;
            onda_s_q       <= '0;
            div_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            clip_q         <= 1'b0;
`ifdef AUDIO_ENVELOPE_EN
            g_q            <= '0;
`endif
        end else begin
            meta_q         <= onda;
            onda_s_q       <= meta_q;
            div_q          <= tick ? '0 : div_q + 1'b1;
            sample_valid_q <= tick;
            if (tick) begin
                sample_q <= sample_d;
                clip_q   <= sat;
`ifdef AUDIO_ENVELOPE_EN
                g_q      <= g;
`endif
            end
        end
    end
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign clip         = clip_q;
    sigma_delta_dac u_dac (
        .clk  (clk),
        .rst  (rst),
        .din  (sample_q),
        .dout (audio_out)
    );
endmodule
